adder_subtractor_seq: RTL and testbench

ADDER_SUBTRACTOR_SEQ -- requirements
Module: adder_subtractor_seq

---
 rtl/adder_subtractor_seq.sv | 148 ++++++++++++++
 tb/tb_adder_subtractor_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_subtractor_seq.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle LSB-first with a
// registered ripple carry, optional signed saturation, valid/ready handshakes.
module adder_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [WIDTH-1:0] x_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic                    carry_p0;
  logic signed [WIDTH-1:0] raw_p0;
  logic signed [WIDTH-1:0] raw_nxt;
  logic signed [WIDTH-1:0] res_nxt;
  logic [CHUNK:0]          slice_sum;
  int                      slice_lo;
  logic                    accept;
  logic                    last_chunk;
  logic                    finish;
  logic                    ovf_nxt;
  logic signed [WIDTH-1:0] result_q;
  logic                    cout_q;
  logic                    overflow_q;
  logic                    zero_q;

  // Clamp toward the sign of x: overflow can only push the result away from it.
  function automatic logic signed [WIDTH-1:0] sat_clamp(
    input logic signed [WIDTH-1:0] raw,
    input logic                    ovf,
    input logic                    x_neg
  );
    if (SAT != 0 && ovf) begin
      return x_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return raw;
  endfunction

  assign accept     = in_valid && (state_q == IDLE);
  assign last_chunk = (cnt_q == LAST_CNT);
  assign finish     = (state_q == BUSY) && last_chunk;
  assign slice_lo   = int'(cnt_q) * CHUNK;

  // ---- stage p0: one CHUNK slice of x + effective B + carry per BUSY cycle
  always_comb begin
    slice_sum = {1'b0, x_p0[slice_lo +: CHUNK]}
              + {1'b0, b_p0[slice_lo +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_p0};
    raw_nxt = raw_p0;
    raw_nxt[slice_lo +: CHUNK] = slice_sum[CHUNK-1:0];
  end

  assign ovf_nxt = (x_p0[WIDTH-1] == b_p0[WIDTH-1]) && (raw_nxt[WIDTH-1] != x_p0[WIDTH-1]);
  assign res_nxt = sat_clamp(raw_nxt, ovf_nxt, x_p0[WIDTH-1]);

  // Operands are captured once at acceptance, so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0     <= x;
      b_p0     <= sel ? ~y : y;
      carry_p0 <= sel ? ~cin : cin;
    end else if (state_q == BUSY) begin
      carry_p0 <= slice_sum[CHUNK];
      raw_p0   <= raw_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---- stage p1: final result and flags, held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (finish) begin
      result_q   <= res_nxt;
      cout_q     <= slice_sum[CHUNK];
      overflow_q <= ovf_nxt;
      zero_q     <= (res_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_adder_subtractor_seq.sv
// Bench for adder_subtractor_seq: directed 8/4 vectors on SAT=0 and SAT=1 copies,
// plus random transactions on several WIDTH/CHUNK/SAT configurations.
module tb_adder_subtractor_seq;

  localparam int NCFG = 8;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] x, y;
  logic       cin, sel, out_ready;
  logic       a_ir, a_ov, a_co, a_of, a_z;
  logic [7:0] a_res;
  logic       b_ir, b_ov, b_co, b_of, b_z;
  logic [7:0] b_res;

  always #5 clk = ~clk;

  adder_subtractor_seq #(.WIDTH(8), .CHUNK(4), .SAT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir),
    .x(x), .y(y), .cin(cin), .sel(sel), .out_valid(a_ov), .out_ready(out_ready),
    .result(a_res), .cout(a_co), .overflow(a_of), .zero(a_z)
  );

  adder_subtractor_seq #(.WIDTH(8), .CHUNK(4), .SAT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir),
    .x(x), .y(y), .cin(cin), .sel(sel), .out_valid(b_ov), .out_ready(out_ready),
    .result(b_res), .cout(b_co), .overflow(b_of), .zero(b_z)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns edges from acceptance to out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic s, output int lat);
    in_valid = 1'b1; x = a; y = b; cin = ci; sel = s;
    @(negedge clk);
    in_valid = 1'b0; x = ~a; y = ~b;
    lat = 0;
    while (!a_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sel = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", a_res, 8'd0);
    chk("rst_out_valid", a_ov, 1'b0);
    chk("rst_in_ready", a_ir, 1'b1);
    chk("rst_flags", {a_co, a_of, a_z}, 3'b000);

    // Operands presented together with reset release.
    rst_n = 1'b1;
    run_op(8'd200, 8'd100, 1'b0, 1'b0, lat);
    chk("add_latency", lat, 2);
    chk("add_result", a_res, 8'd44);
    chk("add_flags", {a_co, a_of, a_z}, 3'b100);
    release_res();

    run_op(8'd0, 8'd1, 1'b0, 1'b1, lat);
    chk("sub0m1_result", a_res, 8'd255);
    chk("sub0m1_flags", {a_co, a_of, a_z}, 3'b000);
    release_res();

    run_op(8'd100, 8'd200, 1'b0, 1'b1, lat);
    chk("sub_ovf_result", a_res, 8'd156);
    chk("sub_ovf_flags", {a_co, a_of}, 2'b01);
    release_res();

    run_op(8'd100, 8'd50, 1'b0, 1'b0, lat);
    chk("add_ovf_result", a_res, 8'd150);
    chk("add_ovf_flag", a_of, 1'b1);
    chk("sat_result", b_res, 8'd127);
    chk("sat_flags", {b_ov, b_co, b_of, b_z}, 4'b1010);
    release_res();

    run_op(8'd255, 8'd1, 1'b0, 1'b0, lat);
    chk("wrap_result", a_res, 8'd0);
    chk("wrap_flags", {a_co, a_of, a_z}, 3'b101);
    release_res();

    run_op(8'd1, 8'd2, 1'b1, 1'b0, lat);
    chk("add_cin_result", a_res, 8'd4);
    release_res();

    run_op(8'd5, 8'd3, 1'b1, 1'b1, lat);
    chk("sub_bin_result", a_res, 8'd1);
    chk("sub_bin_cout", a_co, 1'b1);
    release_res();

    run_op(8'd17, 8'd34, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      x = 8'($urandom); y = 8'($urandom); in_valid = 1'b1; sel = ~sel;
      @(negedge clk);
      chk("hold_result", a_res, 8'd51);
      chk("hold_ctrl", {a_ov, a_ir}, 2'b10);
    end
    in_valid = 1'b0;
    release_res();
    chk("hold_release", {a_ov, a_ir}, 2'b01);
    @(negedge clk);
    chk("idle_quiet", {a_ov, a_ir}, 2'b01);

    in_valid = 1'b1; x = 8'd9; y = 8'd9; cin = 1'b0; sel = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_result", a_res, 8'd0);
    chk("midrst_ctrl", {a_ov, a_ir, a_co, a_of, a_z}, 5'b01000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ov) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    run_op(8'd1, 8'd1, 1'b0, 1'b0, lat);
    chk("after_rst_result", a_res, 8'd2);
    release_res();

    for (int t = 0; t < 30000 && done_cnt < NCFG; t++) @(negedge clk);
    chk("rand_done", done_cnt, NCFG);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic int cfg_w(input int i);
    case (i % 4)
      0, 1:    return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_c(input int i);
    case (i % 4)
      0:       return 8;
      1, 2:    return 4;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_rand
    localparam int GW = cfg_w(g);
    localparam int GC = cfg_c(g);
    localparam int GS = (g >= 4) ? 1 : 0;

    logic          r_n, iv, ir, ov, ordy, ci_s, sl, co, of, zr;
    logic [GW-1:0] xa, ya, res;

    adder_subtractor_seq #(.WIDTH(GW), .CHUNK(GC), .SAT(GS)) u_dut (
      .clk(clk), .rst_n(r_n), .in_valid(iv), .in_ready(ir),
      .x(xa), .y(ya), .cin(ci_s), .sel(sl), .out_valid(ov), .out_ready(ordy),
      .result(res), .cout(co), .overflow(of), .zero(zr)
    );

    initial begin
      logic [GW-1:0] a, b, er;
      logic          ci, s, eco, eov;
      longint        sa, sb, ua, ub, ideal, uf, maxv, minv;
      int            lat;
      r_n = 1'b0; iv = 1'b0; ordy = 1'b0; xa = '0; ya = '0; ci_s = 1'b0; sl = 1'b0;
      maxv = (longint'(1) <<< (GW - 1)) - 1;
      minv = -(longint'(1) <<< (GW - 1));
      repeat (2) @(negedge clk);
      r_n = 1'b1;
      for (int n = 0; n < 40; n++) begin
        a = GW'($urandom); b = GW'($urandom);
        ci = 1'($urandom); s = 1'($urandom);
        if (n % 10 == 0) begin
          a = GW'(maxv); b = GW'(1); s = 1'b0;
        end
        chk($sformatf("cfg%0d_in_ready", g), ir, 1'b1);
        iv = 1'b1; xa = a; ya = b; ci_s = ci; sl = s;
        @(negedge clk);
        iv = 1'b0; xa = GW'($urandom); ya = GW'($urandom); sl = ~s;
        lat = 0;
        while (!ov && lat < 64) begin
          @(negedge clk);
          lat++;
        end
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        if (s) begin
          ideal = sa - sb - longint'(ci);
          uf    = ua - ub - longint'(ci);
          eco   = (uf >= 0);
        end else begin
          ideal = sa + sb + longint'(ci);
          uf    = ua + ub + longint'(ci);
          eco   = ((uf >>> GW) != 0);
        end
        eov = (ideal > maxv) || (ideal < minv);
        er  = GW'(ideal);
        if (GS != 0 && ideal > maxv) er = GW'(maxv);
        if (GS != 0 && ideal < minv) er = GW'(minv);
        chk($sformatf("cfg%0d_latency", g), lat, GW / GC);
        chk($sformatf("cfg%0d_result", g), res, er);
        chk($sformatf("cfg%0d_cout", g), co, eco);
        chk($sformatf("cfg%0d_overflow", g), of, eov);
        chk($sformatf("cfg%0d_zero", g), zr, (er == '0));
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
      end
      done_cnt++;
    end
  end

endmodule
